// File: rtl/bf_pkg.sv
// Shared definitions for the program loader: opcode values, the terminator
// character, bounds of the address and bracket counters, and FSM state encoding.
package bf_pkg;

  localparam logic [3:0] OP_END   = 4'd0;
  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_RIGHT = 4'd3;
  localparam logic [3:0] OP_LEFT  = 4'd4;
  localparam logic [3:0] OP_LOOP  = 4'd5;
  localparam logic [3:0] OP_BACK  = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_IN    = 4'd8;

  localparam logic [7:0] CH_TERM = 8'h21;

  // The last address is kept free so a full program can always be closed by END.
  localparam logic [15:0] ADDR_LAST = 16'hFFFF;
  localparam logic [7:0]  DEPTH_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/bf_char_decode.sv
// Combinational ASCII-to-opcode decode; the terminator decodes to the END opcode.
module bf_char_decode
  import bf_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_cmd_o,
  output logic       is_term_o,
  output logic [3:0] opcode_o
);

  always_comb begin
    is_cmd_o  = 1'b1;
    is_term_o = (char_i == CH_TERM);
    opcode_o  = OP_END;
    case (char_i)
      8'h2B:   opcode_o = OP_INC;
      8'h2D:   opcode_o = OP_DEC;
      8'h3E:   opcode_o = OP_RIGHT;
      8'h3C:   opcode_o = OP_LEFT;
      8'h5B:   opcode_o = OP_LOOP;
      8'h5D:   opcode_o = OP_BACK;
      8'h2E:   opcode_o = OP_OUT;
      8'h2C:   opcode_o = OP_IN;
      default: is_cmd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// Streams an ASCII program into program memory, one opcode per 4-cycle write,
// checking bracket balance and reserving the last address for END.
module program_loader
  import bf_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [15:0] prog_addr,
  output logic [3:0]  prog_data,
  output logic        prog_we,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] prog_len
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  depth_q, depth_d;
  logic [3:0]  data_q, data_d;
  logic        term_q, term_d;

  logic        is_cmd, is_term;
  logic [3:0]  dec_op;

  bf_char_decode u_decode (
    .char_i    (char_in),
    .is_cmd_o  (is_cmd),
    .is_term_o (is_term),
    .opcode_o  (dec_op)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      depth_q <= '0;
      data_q  <= OP_END;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      depth_q <= depth_d;
      data_q  <= data_d;
      term_q  <= term_d;
    end
  end

  // Every output is a decode of registered state, so nothing is combinational from the inputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    depth_d    = depth_q;
    data_d     = data_q;
    term_d     = term_q;
    char_ready = 1'b0;
    prog_we    = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;

    case (state_q)
      ST_IDLE: begin
        char_ready = 1'b1;
        if (char_valid) begin
          if (is_term) begin
            if (depth_q != 8'd0) begin
              state_d = ST_ERR;
            end else begin
              data_d  = OP_END;
              term_d  = 1'b1;
              state_d = ST_SETUP;
            end
          end else if (is_cmd) begin
            if (addr_q == ADDR_LAST) begin
              state_d = ST_ERR;
            end else if ((dec_op == OP_LOOP) && (depth_q == DEPTH_MAX)) begin
              state_d = ST_ERR;
            end else if ((dec_op == OP_BACK) && (depth_q == 8'd0)) begin
              state_d = ST_ERR;
            end else begin
              data_d  = dec_op;
              term_d  = 1'b0;
              state_d = ST_SETUP;
              if (dec_op == OP_LOOP) begin
                depth_d = depth_q + 8'd1;
              end else if (dec_op == OP_BACK) begin
                depth_d = depth_q - 8'd1;
              end
            end
          end
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        prog_we = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        addr_d  = addr_q + 16'd1;
        state_d = term_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: load_done = 1'b1;
      ST_ERR:  load_error = 1'b1;
      default: state_d = ST_ERR;
    endcase
  end

  assign prog_addr = addr_q;
  assign prog_data = data_q;
  assign prog_len  = addr_q;

  // Sanity properties on the decoded outputs; synthesis ignores them.
  assert property (@(posedge clock) !(load_done && load_error));
  assert property (@(posedge clock) disable iff (reset) prog_we |=> !prog_we);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a transaction-level reference model
// checked every cycle, directed program scenarios and randomized programs.
module tb_program_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [15:0] prog_addr;
  logic [3:0]  prog_data;
  logic        prog_we;
  logic        load_done;
  logic        load_error;
  logic [15:0] prog_len;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: remaining busy cycles of the current write, counters and sticky flags.
  bit          modelOn = 1'b0;
  int          mLeft = 0;
  logic [15:0] mAddr = '0;
  int          mDepth = 0;
  int          mPeak = 0;
  logic [3:0]  mData = '0;
  bit          mTerm = 1'b0;
  bit          mDone = 1'b0;
  bit          mErr = 1'b0;

  logic [19:0] dutWr[$];
  int          dutWeCyc[$];
  int          dutPeak = 0;
  logic [19:0] expW[$];

  program_loader dut (
    .clock      (clock),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_we    (prog_we),
    .load_done  (load_done),
    .load_error (load_error),
    .prog_len   (prog_len)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  function automatic int opOf(input logic [7:0] c);
    string cmds = "+-><[].,";
    for (int i = 0; i < cmds.len(); i++) begin
      if (cmds[i] == c) return i + 1;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model advances on the same edge the DUT samples; it only looks at bench-driven inputs.
  always @(posedge clock) begin
    int op;
    if (reset) begin
      modelOn = 1'b1;
      mLeft = 0; mAddr = '0; mDepth = 0; mPeak = 0;
      mData = '0; mTerm = 1'b0; mDone = 1'b0; mErr = 1'b0;
    end else if (mLeft != 0) begin
      mLeft--;
      if (mLeft == 0) begin
        mAddr = mAddr + 16'd1;
        if (mTerm) mDone = 1'b1;
      end
    end else if (!mDone && !mErr && char_valid) begin
      op = opOf(char_in);
      if (char_in == 8'h21) begin
        if (mDepth != 0) mErr = 1'b1;
        else begin mData = 4'd0; mTerm = 1'b1; mLeft = 3; end
      end else if (op != 0) begin
        if (mAddr == 16'hFFFF) mErr = 1'b1;
        else if (char_in == 8'h5B && mDepth == 255) mErr = 1'b1;
        else if (char_in == 8'h5D && mDepth == 0) mErr = 1'b1;
        else begin
          if (char_in == 8'h5B) mDepth++;
          if (char_in == 8'h5D) mDepth--;
          if (mDepth > mPeak) mPeak = mDepth;
          mData = op[3:0];
          mTerm = 1'b0;
          mLeft = 3;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [3:0] expCtl;
    if (modelOn) begin
      expCtl = {(!mDone && !mErr && mLeft == 0), (mLeft == 2), mDone, mErr};
      checkOutput("cycle ready/we/done/error", int'({char_ready, prog_we, load_done, load_error}), int'(expCtl));
      checkOutput("cycle prog_len", int'(prog_len), int'(mAddr));
      checkOutput("cycle depth", int'(dut.depth_q), mDepth);
      if (mLeft != 0)
        checkOutput("cycle addr/data", int'({prog_addr, prog_data}), int'({mAddr, mData}));
    end
  end

  always @(negedge clock) begin
    if (prog_we) begin
      dutWr.push_back({prog_addr, prog_data});
      dutWeCyc.push_back(cycle);
    end
    if (int'(dut.depth_q) > dutPeak) dutPeak = int'(dut.depth_q);
  end

  task automatic waitSettle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    char_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    dutWr.delete();
    dutWeCyc.delete();
    dutPeak = 0;
  endtask

  task automatic sendChar(input byte c, input bit gaps, inout int stalls);
    int waited;
    if (mDone || mErr) return;
    if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clock);
    char_in = c;
    char_valid = 1'b1;
    waited = 0;
    while (!char_ready && !(mDone || mErr) && waited < 40) begin
      @(negedge clock);
      waited++;
      stalls++;
    end
    if (waited >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout: char_ready %0b after %0d cycles, required 1", char_ready, waited);
    end
    @(negedge clock);
    char_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string s, input bit gaps, output int stalls);
    stalls = 0;
    for (int i = 0; i < s.len(); i++) sendChar(s[i], gaps, stalls);
  endtask

  task automatic checkWrites(input string name, input logic [19:0] exp[$]);
    checkOutput({name, " write count"}, dutWr.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dutWr.size(); i++)
      checkOutput($sformatf("%s write %0d {addr,data}", name, i), int'(dutWr[i]), int'(exp[i]));
  endtask

  task automatic preload();
    string cmds = "+-><.,";
    int dummy = 0;
    doReset();
    for (int i = 0; i < 65534; i++) sendChar(cmds[$urandom_range(0, 5)], 1'b0, dummy);
    waitSettle(4);
    checkOutput("preload prog_len", int'(prog_len), 65534);
  endtask

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    int dummy;
    int open;
    int len;
    int r;
    int n;
    byte c;
    string junk = "ab xyz\n09=Q";
    string cmds = "+-><.,";

    reset = 1'b1;
    char_valid = 1'b0;
    char_in = 8'h00;

    // Reset state
    doReset();
    checkOutput("reset char_ready", int'(char_ready), 1);
    checkOutput("reset prog_we", int'(prog_we), 0);
    checkOutput("reset prog_len", int'(prog_len), 0);
    checkOutput("reset prog_addr", int'(prog_addr), 0);
    checkOutput("reset prog_data", int'(prog_data), 0);
    checkOutput("reset done/error", int'({load_done, load_error}), 0);

    // "+>!"
    applyStimulus("+>!", 1'b0, st);
    waitSettle(5);
    expW = '{20'h00001, 20'h00013, 20'h00020};
    checkWrites("+>!", expW);
    if (dutWeCyc.size() == 3) begin
      checkOutput("+>! we spacing 1", dutWeCyc[1] - dutWeCyc[0], 4);
      checkOutput("+>! we spacing 2", dutWeCyc[2] - dutWeCyc[1], 4);
    end
    checkOutput("+>! load_done", int'(load_done), 1);
    checkOutput("+>! prog_len", int'(prog_len), 3);
    checkOutput("+>! model length", int'(mAddr), 3);

    // "a + b\n!"
    doReset();
    applyStimulus("a ", 1'b0, st);
    checkOutput("discard stalls 1", st, 0);
    applyStimulus("+", 1'b0, st);
    waitSettle(3);
    applyStimulus(" b\n", 1'b0, st);
    checkOutput("discard stalls 2", st, 0);
    applyStimulus("!", 1'b0, st);
    waitSettle(5);
    expW = '{20'h00001, 20'h00010};
    checkWrites("a+b", expW);
    checkOutput("a+b prog_len", int'(prog_len), 2);
    checkOutput("a+b load_done", int'(load_done), 1);

    // "[[-]]!"
    doReset();
    applyStimulus("[[-]]!", 1'b1, st);
    waitSettle(5);
    expW = '{20'h00005, 20'h00015, 20'h00022, 20'h00036, 20'h00046, 20'h00050};
    checkWrites("nested", expW);
    checkOutput("nested depth peak", dutPeak, 2);
    checkOutput("nested model peak", mPeak, 2);
    checkOutput("nested load_error", int'(load_error), 0);
    checkOutput("nested load_done", int'(load_done), 1);

    // "+]"
    doReset();
    applyStimulus("+]", 1'b0, st);
    checkOutput("+] load_error next cycle", int'(load_error), 1);
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (char_ready) n++;
    end
    checkOutput("+] char_ready cycles after error", n, 0);
    expW = '{20'h00001};
    checkWrites("+]", expW);

    // "[+!"
    doReset();
    applyStimulus("[+!", 1'b1, st);
    waitSettle(5);
    expW = '{20'h00005, 20'h00011};
    checkWrites("[+!", expW);
    checkOutput("[+! load_error", int'(load_error), 1);
    checkOutput("[+! load_done", int'(load_done), 0);

    // Reset during STROBE
    doReset();
    applyStimulus("+", 1'b0, st);
    n = 0;
    while (!prog_we && n < 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput("abort reached strobe", int'(prog_we), 1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort prog_we", int'(prog_we), 0);
    checkOutput("abort prog_addr", int'(prog_addr), 0);
    checkOutput("abort prog_len", int'(prog_len), 0);
    reset = 1'b0;
    checkOutput("abort char_ready", int'(char_ready), 1);
    @(negedge clock);
    checkOutput("abort char_ready after", int'(char_ready), 1);
    checkOutput("abort prog_len after", int'(prog_len), 0);

    // Bracket depth saturation
    doReset();
    dummy = 0;
    for (int i = 0; i < 255; i++) sendChar(8'h5B, 1'b0, dummy);
    sendChar(8'h5B, 1'b0, dummy);
    waitSettle(3);
    checkOutput("depth255 peak", dutPeak, 255);
    checkOutput("depth255 model peak", mPeak, 255);
    checkOutput("depth255 load_error", int'(load_error), 1);
    checkOutput("depth255 write count", dutWr.size(), 255);

    // Randomized programs
    for (int p = 0; p < 8; p++) begin
      doReset();
      open = 0;
      dummy = 0;
      len = $urandom_range(4, 24);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r < 3) c = junk[$urandom_range(0, junk.len() - 1)];
        else if (r == 3) begin c = 8'h5B; open++; end
        else if (r == 4 && (open > 0 || $urandom_range(0, 9) == 0)) begin c = 8'h5D; open--; end
        else c = cmds[$urandom_range(0, 5)];
        sendChar(c, 1'b1, dummy);
      end
      if ($urandom_range(0, 1) == 1) begin
        while (open > 0) begin
          sendChar(8'h5D, 1'b1, dummy);
          open--;
        end
      end
      sendChar(8'h21, 1'b1, dummy);
      waitSettle(6);
      checkOutput($sformatf("random %0d terminal flags", p), int'(load_done) + int'(load_error), 1);
    end

    // Address limit: "+!" from 0xFFFE
    preload();
    dummy = 0;
    sendChar(8'h2B, 1'b0, dummy);
    sendChar(8'h21, 1'b0, dummy);
    waitSettle(5);
    checkOutput("limit write count", dutWr.size(), 65536);
    if (dutWr.size() == 65536) begin
      checkOutput("limit '+' write", int'(dutWr[65534]), int'({16'hFFFE, 4'd1}));
      checkOutput("limit END write", int'(dutWr[65535]), int'({16'hFFFF, 4'd0}));
    end
    checkOutput("limit load_done", int'(load_done), 1);
    checkOutput("limit load_error", int'(load_error), 0);

    // Address limit: "++" from 0xFFFE
    preload();
    dummy = 0;
    sendChar(8'h2B, 1'b0, dummy);
    sendChar(8'h2B, 1'b0, dummy);
    waitSettle(5);
    checkOutput("limit++ write count", dutWr.size(), 65535);
    if (dutWr.size() == 65535)
      checkOutput("limit++ last write", int'(dutWr[65534]), int'({16'hFFFE, 4'd1}));
    checkOutput("limit++ load_error", int'(load_error), 1);
    checkOutput("limit++ load_done", int'(load_done), 0);

    waitSettle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
